// File: rtl/serial_2wire_regwr_if.sv
// ----------------------------------------------------------------------------
// serial_2wire_regwr_if
// Bus between the register-write sequencer and the serial_2wire master.
//
// Handshake: the sequencer holds out_ser_enable high for a whole transaction
// (address byte then data byte). out_ser_data stays stable while enable is
// high and changes only when the sequencer moves from one byte to the next.
// The master accepts each byte and reports it with a rising edge on
// in_ser_next. in_ser_ready means the master is idle and can start a new
// transaction. in_ser_err reports a bus error and aborts the transaction.
//
// Signals
//   out_ser_enable  sequencer -> master  transaction enable
//   out_ser_data    sequencer -> master  byte currently offered (BITS wide)
//   in_ser_ready    master -> sequencer  master idle
//   in_ser_next     master -> sequencer  byte consumed (edge-detected)
//   in_ser_err      master -> sequencer  bus error
// Modports: master = sequencer side, slave = serial_2wire side.
// ----------------------------------------------------------------------------
interface serial_2wire_regwr_if #(
    parameter int BITS = 8
);
    logic            out_ser_enable;
    logic [BITS-1:0] out_ser_data;
    logic            in_ser_ready;
    logic            in_ser_next;
    logic            in_ser_err;

    modport master (
        output out_ser_enable,
        output out_ser_data,
        input  in_ser_ready,
        input  in_ser_next,
        input  in_ser_err
    );

    modport slave (
        input  out_ser_enable,
        input  out_ser_data,
        output in_ser_ready,
        output in_ser_next,
        output in_ser_err
    );
endinterface

// File: rtl/serial_2wire_regwr.sv
// ----------------------------------------------------------------------------
// serial_2wire_regwr
// Register-write sequencer in front of a serial_2wire master. (address, data)
// pairs are buffered in a FIFO and each pair is sent as one transaction:
// the address byte, then the data byte, with enable held across both. On a
// bus error the entry is dropped. When SERIAL_2WIRE_REGWR_RETRY_EN is
// defined, the entry is first retried up to RETRIES times.
//
// Optional feature macro: SERIAL_2WIRE_REGWR_RETRY_EN (undefined by default)
//
// Ports
//   in_clk, in_rst      clock, synchronous active-high reset
//   in_push             push one pair (in_reg_addr, in_reg_data)
//   out_full/out_empty  FIFO status
//   out_busy            sequencer not idle
//   out_done            1-cycle pulse when an entry completes or is dropped
//   out_err/out_err_cnt sticky drop flag and saturating drop count
//   in_clr_err          clears out_err/out_err_cnt (wins over a same-cycle drop)
//   ser                 serial_2wire bus (master modport)
//   out_state           current FSM state, for observation
// ----------------------------------------------------------------------------
module serial_2wire_regwr #(
    parameter int BITS    = 8,
    parameter int DEPTH   = 8,
    parameter int RETRIES = 2
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_push,
    input  logic [BITS-1:0]     in_reg_addr,
    input  logic [BITS-1:0]     in_reg_data,
    output logic                out_full,
    output logic                out_empty,
    output logic                out_busy,
    output logic                out_done,
    output logic                out_err,
    output logic [7:0]          out_err_cnt,
    input  logic                in_clr_err,
    serial_2wire_regwr_if.master ser,
    output logic [2:0]          out_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE_ADDR = 3'd1,
        ST_WRITE_DATA = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RECOVER    = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_enable;
    logic [BITS-1:0] r_data;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_err_cnt;
    logic            r_last_next;

    logic [BITS-1:0] r_mem_addr [DEPTH];
    logic [BITS-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

`ifdef SERIAL_2WIRE_REGWR_RETRY_EN
    localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam logic [RW-1:0] RETRIES_W = RW'(RETRIES);
    logic [RW-1:0]   r_retry_cnt;
`endif

    logic w_next_edge;
    logic w_pop;
    logic w_drop;
    logic w_retry;
    logic w_push_ok;

    assign w_next_edge = ser.in_ser_next & ~r_last_next;

    assign out_full    = (r_count == (AW+1)'(DEPTH));
    assign out_empty   = (r_count == '0);
    assign out_busy    = (r_state != ST_IDLE);
    assign out_done    = r_done;
    assign out_err     = r_err;
    assign out_err_cnt = r_err_cnt;
    assign out_state   = r_state;
    assign ser.out_ser_enable = r_enable;
    assign ser.out_ser_data   = r_data;

    // The head entry leaves the FIFO only when its transaction finishes,
    // either successfully in WaitDone or by being dropped from Recover.
    always_comb begin
        w_pop   = 1'b0;
        w_drop  = 1'b0;
        w_retry = 1'b0;
        case (r_state)
            ST_WAIT_DONE: begin
                if (!ser.in_ser_err && ser.in_ser_ready) w_pop = 1'b1;
            end
            ST_RECOVER: begin
                if (ser.in_ser_ready) begin
`ifdef SERIAL_2WIRE_REGWR_RETRY_EN
                    if (r_retry_cnt < RETRIES_W) begin
                        w_retry = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                        w_pop  = 1'b1;
                    end
`else
                    w_drop = 1'b1;
                    w_pop  = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // A push into a full FIFO still lands if the head is popped this cycle.
    assign w_push_ok = in_push && (!out_full || w_pop);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= ST_IDLE;
            r_enable    <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_last_next <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
`ifdef SERIAL_2WIRE_REGWR_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_last_next <= ser.in_ser_next;
            r_done      <= 1'b0;

            if (in_clr_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= 8'd0;
            end else if (w_drop) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end

            if (w_push_ok) begin
                r_mem_addr[r_wr_ptr] <= in_reg_addr;
                r_mem_data[r_wr_ptr] <= in_reg_data;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase

`ifdef SERIAL_2WIRE_REGWR_RETRY_EN
            if (w_pop)        r_retry_cnt <= '0;
            else if (w_retry) r_retry_cnt <= r_retry_cnt + RW'(1);
`endif

            // Bus outputs change only on transitions, keeping data stable
            // for as long as enable is high. Errors beat byte strobes.
            case (r_state)
                ST_IDLE: begin
                    if (!out_empty && ser.in_ser_ready) begin
                        r_state  <= ST_WRITE_ADDR;
                        r_enable <= 1'b1;
                        r_data   <= r_mem_addr[r_rd_ptr];
                    end
                end
                ST_WRITE_ADDR: begin
                    if (ser.in_ser_err) begin
                        r_state  <= ST_RECOVER;
                        r_enable <= 1'b0;
                        r_data   <= '0;
                    end else if (w_next_edge) begin
                        r_state  <= ST_WRITE_DATA;
                        r_data   <= r_mem_data[r_rd_ptr];
                    end
                end
                ST_WRITE_DATA: begin
                    if (ser.in_ser_err) begin
                        r_state  <= ST_RECOVER;
                        r_enable <= 1'b0;
                        r_data   <= '0;
                    end else if (w_next_edge) begin
                        r_state  <= ST_WAIT_DONE;
                        r_enable <= 1'b0;
                        r_data   <= '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ser.in_ser_err) begin
                        r_state <= ST_RECOVER;
                    end else if (ser.in_ser_ready) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (w_retry) begin
                        r_state  <= ST_WRITE_ADDR;
                        r_enable <= 1'b1;
                        r_data   <= r_mem_addr[r_rd_ptr];
                    end else if (w_drop) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= 1'b0;
                    r_data   <= '0;
                end
            endcase
        end
    end
endmodule
